// File: rtl/voice_msg_controller.sv
// Keypad-driven menu controller for N_SLOTS voice messages held in external RAM.
// Runs one RAM handshake per audio sample for record/playback and scales playback by volume.
module voice_msg_controller #(
  parameter int N_SLOTS    = 5,
  parameter int SLOT_DEPTH = 4096,
  parameter int SAMPLE_W   = 16,
  parameter int VOL_MAX    = 7,
  parameter int ADDR_W     = $clog2(N_SLOTS) + $clog2(SLOT_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] adc_sample,
  output logic [SAMPLE_W-1:0] dac_sample,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [SAMPLE_W-1:0] ram_wdata,
  input  logic                ram_ack,
  input  logic [SAMPLE_W-1:0] ram_rdata,
  output logic [2:0]          mode,
  output logic [3:0]          cur_slot,
  output logic [N_SLOTS-1:0]  slot_valid,
  output logic                storage_full,
  output logic                overrun,
  output logic [2:0]          volume
);

  localparam int IDX_W  = $clog2(SLOT_DEPTH);
  localparam int SLOT_W = ADDR_W - IDX_W;
  localparam int PW     = SAMPLE_W + 3;
  localparam logic [IDX_W:0] DEPTH     = (IDX_W+1)'(SLOT_DEPTH);
  localparam logic [IDX_W:0] IDX_ONE   = (IDX_W+1)'(1);
  localparam logic [2:0]     VOL_TOP   = 3'(VOL_MAX);
  localparam logic [2:0]     VOL_UNITY = 3'd4;

  typedef enum logic [2:0] {
    MENU        = 3'd0,
    SEL_PLAY    = 3'd1,
    SEL_REC     = 3'd2,
    SEL_DEL     = 3'd3,
    RECORD      = 3'd4,
    PLAY        = 3'd5,
    CONFIRM_ALL = 3'd6
  } state_t;

  state_t               state, state_n;
  logic [3:0]           cur_slot_n;
  logic [N_SLOTS-1:0]   slot_valid_n;
  logic [IDX_W:0]       slot_len   [N_SLOTS];
  logic [IDX_W:0]       slot_len_n [N_SLOTS];
  logic [2:0]           volume_n;
  logic [IDX_W:0]       idx, idx_n, limit, cur_len;
  logic                 stop_pending, stop_pending_n;
  logic                 ram_req_n, ram_we_n, overrun_n, key_stop;
  logic [ADDR_W-1:0]    ram_addr_n;
  logic [SAMPLE_W-1:0]  ram_wdata_n, dac_n, scaled;
  logic [N_SLOTS-1:0]   key_hot, cur_hot;
  logic [SLOT_W-1:0]    slot_m1;
  logic signed [PW-1:0] prod, shifted;

  assign mode         = state;
  assign storage_full = &slot_valid;
  assign key_stop     = key_valid && (key_code == 4'h0);
  assign slot_m1      = SLOT_W'(cur_slot - 4'd1);
  assign limit        = (state == RECORD) ? DEPTH : cur_len;

  always_comb begin
    key_hot = '0;
    cur_hot = '0;
    cur_len = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      key_hot[i] = (key_code == 4'(i + 1));
      cur_hot[i] = (cur_slot == 4'(i + 1));
      if (cur_slot == 4'(i + 1)) cur_len = slot_len[i];
    end
  end

  // Volume 4 is unity: multiply by the step, divide by four, clamp to the sample range.
  always_comb begin
    prod    = $signed({{3{ram_rdata[SAMPLE_W-1]}}, ram_rdata}) * $signed({{SAMPLE_W{1'b0}}, volume});
    shifted = prod >>> 2;
    if ((~|shifted[PW-1:SAMPLE_W-1]) || (&shifted[PW-1:SAMPLE_W-1]))
      scaled = shifted[SAMPLE_W-1:0];
    else if (shifted[PW-1])
      scaled = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      scaled = {1'b0, {(SAMPLE_W-1){1'b1}}};
  end

  always_comb begin
    state_n        = state;
    cur_slot_n     = cur_slot;
    slot_valid_n   = slot_valid;
    slot_len_n     = slot_len;
    volume_n       = volume;
    idx_n          = idx;
    stop_pending_n = stop_pending;
    ram_req_n      = ram_req;
    ram_we_n       = ram_we;
    ram_addr_n     = ram_addr;
    ram_wdata_n    = ram_wdata;
    dac_n          = dac_sample;
    overrun_n      = overrun;
    case (state)
      MENU: if (key_valid) begin
        case (key_code)
          4'hA: state_n = SEL_PLAY;
          4'hB: state_n = SEL_REC;
          4'hC: state_n = SEL_DEL;
          4'hD: state_n = CONFIRM_ALL;
          4'hE: if (volume < VOL_TOP) volume_n = volume + 3'd1;
          4'hF: if (volume != 3'd0) volume_n = volume - 3'd1;
          default: ;
        endcase
      end
      SEL_PLAY, SEL_REC, SEL_DEL: if (key_valid) begin
        state_n = MENU;
        if (|key_hot) begin
          case (state)
            SEL_PLAY: if (|(key_hot & slot_valid)) begin
              state_n        = PLAY;
              cur_slot_n     = key_code;
              idx_n          = '0;
              stop_pending_n = 1'b0;
              overrun_n      = 1'b0;
            end
            SEL_REC: begin
              state_n        = RECORD;
              cur_slot_n     = key_code;
              idx_n          = '0;
              stop_pending_n = 1'b0;
              overrun_n      = 1'b0;
              slot_valid_n   = slot_valid & ~key_hot;
              for (int i = 0; i < N_SLOTS; i++) if (key_hot[i]) slot_len_n[i] = '0;
            end
            default: begin
              slot_valid_n = slot_valid & ~key_hot;
              for (int i = 0; i < N_SLOTS; i++) if (key_hot[i]) slot_len_n[i] = '0;
            end
          endcase
        end
      end
      CONFIRM_ALL: if (key_valid) begin
        state_n = MENU;
        if (key_code == 4'hD) begin
          slot_valid_n = '0;
          for (int i = 0; i < N_SLOTS; i++) slot_len_n[i] = '0;
        end
      end
      RECORD, PLAY: begin
        // A pending request always finishes first; a stop seen meanwhile is remembered.
        if (ram_req) begin
          if (key_stop) stop_pending_n = 1'b1;
          if (sample_tick) overrun_n = 1'b1;
          if (ram_ack) begin
            ram_req_n = 1'b0;
            idx_n     = idx + IDX_ONE;
            if (!ram_we) dac_n = scaled;
          end
        end else if (stop_pending || key_stop || (idx == limit)) begin
          if (state == RECORD) begin
            for (int i = 0; i < N_SLOTS; i++) begin
              if (cur_hot[i]) begin
                slot_len_n[i]   = idx;
                slot_valid_n[i] = (idx != '0);
              end
            end
          end
          state_n        = MENU;
          cur_slot_n     = '0;
          stop_pending_n = 1'b0;
          dac_n          = '0;
        end else if (sample_tick) begin
          ram_req_n  = 1'b1;
          ram_we_n   = (state == RECORD);
          ram_addr_n = {slot_m1, idx[IDX_W-1:0]};
          if (state == RECORD) ram_wdata_n = adc_sample;
        end
        if (state == PLAY && key_valid) begin
          if (key_code == 4'hE && volume < VOL_TOP) volume_n = volume + 3'd1;
          if (key_code == 4'hF && volume != 3'd0)   volume_n = volume - 3'd1;
        end
      end
      default: state_n = MENU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= MENU;
      cur_slot     <= '0;
      slot_valid   <= '0;
      for (int i = 0; i < N_SLOTS; i++) slot_len[i] <= '0;
      volume       <= VOL_UNITY;
      idx          <= '0;
      stop_pending <= 1'b0;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      dac_sample   <= '0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cur_slot     <= cur_slot_n;
      slot_valid   <= slot_valid_n;
      slot_len     <= slot_len_n;
      volume       <= volume_n;
      idx          <= idx_n;
      stop_pending <= stop_pending_n;
      ram_req      <= ram_req_n;
      ram_we       <= ram_we_n;
      ram_addr     <= ram_addr_n;
      ram_wdata    <= ram_wdata_n;
      dac_sample   <= dac_n;
      overrun      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_voice_msg_controller.sv
// Scoreboard bench for voice_msg_controller: expected RAM transactions and playback samples
// are queued by the stimulus and checked by the RAM responder/monitor as the DUT presents them.
module tb_voice_msg_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        sample_tick;
  logic [15:0] adc_sample;
  logic [15:0] dac_sample;
  logic        ram_req, ram_we;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic [2:0]  mode;
  logic [3:0]  cur_slot;
  logic [4:0]  slot_valid;
  logic        storage_full, overrun;
  logic [2:0]  volume;

  voice_msg_controller dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .sample_tick(sample_tick), .adc_sample(adc_sample), .dac_sample(dac_sample),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .mode(mode), .cur_slot(cur_slot),
    .slot_valid(slot_valid), .storage_full(storage_full), .overrun(overrun), .volume(volume)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] dac;
  } txn_t;

  txn_t        expQ[$];
  int          nChecks = 0;
  int          nErrors = 0;
  int          ackLatency = 3;
  logic        holdAck = 1'b0;
  logic [15:0] rdataValue = 16'h0000;
  int          ackCnt;
  txn_t        cur;
  logic        dacPend;
  logic [15:0] dacExp;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWrite(input logic [14:0] addr, input logic [15:0] wdata);
    txn_t t;
    t.we = 1'b1; t.addr = addr; t.wdata = wdata; t.dac = 16'h0;
    expQ.push_back(t);
  endtask

  task automatic pushRead(input logic [14:0] addr, input logic [15:0] dac);
    txn_t t;
    t.we = 1'b0; t.addr = addr; t.wdata = 16'h0; t.dac = dac;
    expQ.push_back(t);
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendTick(input logic [15:0] val);
    @(negedge clk);
    sample_tick = 1'b1;
    adc_sample  = val;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput(name, expQ.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // RAM model and monitor: acks after ackLatency cycles and checks each completed transaction.
  initial begin
    ram_ack   = 1'b0;
    ram_rdata = 16'h0;
    ackCnt    = 0;
    dacPend   = 1'b0;
    dacExp    = 16'h0;
    forever begin
      @(negedge clk);
      ram_ack = 1'b0;
      if (dacPend) begin
        dacPend = 1'b0;
        checkOutput("dac_sample", dac_sample, dacExp);
      end
      if (reset || !ram_req || holdAck) begin
        ackCnt = 0;
      end else begin
        ackCnt++;
        if (ackCnt >= ackLatency) begin
          ackCnt    = 0;
          ram_ack   = 1'b1;
          ram_rdata = rdataValue;
          if (expQ.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL unexpected_ram_req: got we=%0b addr=0x%0h, expected none", ram_we, ram_addr);
          end else begin
            cur = expQ.pop_front();
            checkOutput("ram_we", ram_we, cur.we);
            checkOutput("ram_addr", ram_addr, cur.addr);
            if (cur.we) checkOutput("ram_wdata", ram_wdata, cur.wdata);
            else begin
              dacPend = 1'b1;
              dacExp  = cur.dac;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; sample_tick = 1'b0; adc_sample = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_mode", mode, 0);
    checkOutput("reset_cur_slot", cur_slot, 0);
    checkOutput("reset_slot_valid", slot_valid, 0);
    checkOutput("reset_volume", volume, 4);
    checkOutput("reset_ram_req", ram_req, 0);
    checkOutput("reset_dac", dac_sample, 0);
    checkOutput("reset_overrun", overrun, 0);

    $display("[TB] record slot 2, ten samples");
    applyStimulus(4'hB);
    applyStimulus(4'h2);
    checkOutput("rec_mode", mode, 4);
    checkOutput("rec_cur_slot", cur_slot, 2);
    for (int i = 0; i < 10; i++) begin
      pushWrite(15'h1000 + 15'(i), 16'h0100 + 16'(i));
      sendTick(16'h0100 + 16'(i));
    end
    waitDrain("rec2_drain");
    applyStimulus(4'h0);
    checkOutput("rec2_slot_valid", slot_valid, 5'b00010);
    checkOutput("rec2_mode", mode, 0);

    $display("[TB] play slot 2 at unity volume");
    rdataValue = 16'h1000;
    applyStimulus(4'hA);
    applyStimulus(4'h2);
    checkOutput("play_mode", mode, 5);
    for (int i = 0; i < 10; i++) begin
      pushRead(15'h1000 + 15'(i), 16'h1000);
      sendTick(16'h0);
    end
    waitDrain("play4_drain");
    checkOutput("play4_exit_mode", mode, 0);
    checkOutput("play4_exit_dac", dac_sample, 0);

    $display("[TB] play slot 2 at full volume with saturation");
    repeat (4) applyStimulus(4'hE);
    checkOutput("volume_max", volume, 7);
    rdataValue = 16'h7000;
    applyStimulus(4'hA);
    applyStimulus(4'h2);
    for (int i = 0; i < 10; i++) begin
      pushRead(15'h1000 + 15'(i), 16'h7FFF);
      sendTick(16'h0);
    end
    waitDrain("play7_drain");
    checkOutput("play7_exit_mode", mode, 0);

    $display("[TB] overrun while recording slot 1");
    applyStimulus(4'hB);
    applyStimulus(4'h1);
    holdAck = 1'b1;
    pushWrite(15'h0000, 16'h0AAA);
    sendTick(16'h0AAA);
    sendTick(16'h0BBB);
    checkOutput("overrun_set", overrun, 1);
    checkOutput("overrun_req_held", ram_req, 1);
    holdAck = 1'b0;
    waitDrain("overrun_drain");
    applyStimulus(4'h0);
    checkOutput("overrun_slot_valid", slot_valid, 5'b00011);
    applyStimulus(4'hA);
    applyStimulus(4'h1);
    checkOutput("play_entry_overrun", overrun, 0);
    pushRead(15'h0000, 16'h7FFF);
    sendTick(16'h0);
    waitDrain("play1_drain");
    checkOutput("play1_len1_mode", mode, 0);

    $display("[TB] fill remaining slots, then delete all");
    for (int s = 3; s <= 5; s++) begin
      applyStimulus(4'hB);
      applyStimulus(4'(s));
      pushWrite(15'((s - 1) << 12), 16'h0300 + 16'(s));
      sendTick(16'h0300 + 16'(s));
      waitDrain("fill_drain");
      applyStimulus(4'h0);
    end
    checkOutput("full_slot_valid", slot_valid, 5'b11111);
    checkOutput("full_flag", storage_full, 1);
    applyStimulus(4'hD);
    checkOutput("confirm_mode", mode, 6);
    applyStimulus(4'hD);
    checkOutput("delall_slot_valid", slot_valid, 0);
    checkOutput("delall_full", storage_full, 0);
    applyStimulus(4'hD);
    applyStimulus(4'h1);
    checkOutput("cancel_mode", mode, 0);
    checkOutput("cancel_slot_valid", slot_valid, 0);

    $display("[TB] play request on an empty slot");
    applyStimulus(4'hA);
    applyStimulus(4'h3);
    repeat (8) @(negedge clk);
    checkOutput("empty_play_mode", mode, 0);
    checkOutput("empty_play_req", ram_req, 0);

    $display("[TB] asynchronous reset during a pending write");
    applyStimulus(4'hB);
    applyStimulus(4'h2);
    holdAck = 1'b1;
    sendTick(16'h5555);
    checkOutput("pre_reset_req", ram_req, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_req", ram_req, 0);
    checkOutput("async_reset_we", ram_we, 0);
    checkOutput("async_reset_addr", ram_addr, 0);
    checkOutput("async_reset_wdata", ram_wdata, 0);
    checkOutput("async_reset_mode", mode, 0);
    checkOutput("async_reset_slot_valid", slot_valid, 0);
    checkOutput("async_reset_volume", volume, 4);
    @(negedge clk);
    holdAck = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] volume floor and silent playback");
    repeat (6) applyStimulus(4'hF);
    checkOutput("volume_min", volume, 0);
    applyStimulus(4'hB);
    applyStimulus(4'h1);
    pushWrite(15'h0000, 16'h0111);
    sendTick(16'h0111);
    pushWrite(15'h0001, 16'h0222);
    sendTick(16'h0222);
    waitDrain("rec_vol0_drain");
    applyStimulus(4'h0);
    checkOutput("rec_vol0_slot_valid", slot_valid, 5'b00001);
    rdataValue = 16'h1234;
    applyStimulus(4'hA);
    applyStimulus(4'h1);
    pushRead(15'h0000, 16'h0000);
    sendTick(16'h0);
    pushRead(15'h0001, 16'h0000);
    sendTick(16'h0);
    waitDrain("play_vol0_drain");
    checkOutput("play_vol0_exit_mode", mode, 0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/voice_msg_controller.md
Name: voice_msg_controller

Overview:
- Parametrised successor to the fixed five-message keypad/menu logic.
- Manages N_SLOTS recorded voice messages in external RAM. Decodes debounced keypad events into a menu FSM (play, record, delete, delete-all, volume) and runs the RAM write and read handshakes per audio sample.
- Applies volume scaling to playback samples.
- Sits between the keypad debouncers, the audio codec sample stream and the memory interface; mode/status ports feed the PicoBlaze input ports.

Parameters:
- N_SLOTS, 5, number of message slots (1..15).
- SLOT_DEPTH, 4096, samples per slot; must be a power of two.
- SAMPLE_W, 16, signed audio sample width.
- VOL_MAX, 7, highest volume step; unity gain is step 4.
- ADDR_W, clog2(N_SLOTS)+clog2(SLOT_DEPTH), RAM word address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code is valid
- key_code  in  4  0=stop/cancel, 1..N_SLOTS=slot digit, A=play, B=record, C=delete, D=delete-all, E=vol up, F=vol down
- sample_tick  in  1  one-cycle strobe at audio sample rate
- adc_sample  in  SAMPLE_W  codec capture sample, valid on sample_tick
- dac_sample  out  SAMPLE_W  scaled playback sample
- ram_req  out  1  RAM request; held until ram_ack
- ram_we  out  1  1=write, 0=read; stable while ram_req
- ram_addr  out  ADDR_W  {slot-1, index}
- ram_wdata  out  SAMPLE_W  write data
- ram_ack  in  1  one-cycle completion; ram_rdata valid same cycle for reads
- ram_rdata  in  SAMPLE_W  read data
- mode  out  3  0 MENU, 1 SEL_PLAY, 2 SEL_REC, 3 SEL_DEL, 4 RECORD, 5 PLAY, 6 CONFIRM_ALL
- cur_slot  out  4  active slot, 1-based; 0 when none
- slot_valid  out  N_SLOTS  bit i set = slot i+1 holds a message
- storage_full  out  1  all slot_valid bits set
- overrun  out  1  sticky; a sample was dropped because a RAM request was still pending
- volume  out  3  current volume step

Behaviour:
- Reset values: mode=MENU, cur_slot=0, slot_valid=0, every slot length=0, volume=4, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, dac_sample=0, overrun=0.
- MENU key handling:
  - A->SEL_PLAY, B->SEL_REC, C->SEL_DEL, D->CONFIRM_ALL.
  - E/F step volume, saturating at VOL_MAX/0.
  - All other keys are ignored.
- SEL_* states:
  - Digit 1..N_SLOTS selects the slot. Digit 0 or any other key returns to MENU.
  - SEL_PLAY on an empty slot returns to MENU with no RAM traffic.
  - SEL_REC on any slot goes to RECORD. An occupied slot is overwritten: its valid bit clears on entry.
  - SEL_DEL clears that slot's valid bit and length, then returns to MENU in the same cycle.
- CONFIRM_ALL:
  - D clears every slot in one cycle, then returns to MENU.
  - Any other key cancels back to MENU.
- RECORD:
  - Each sample_tick with no pending request issues ram_req=1, ram_we=1, ram_addr={slot-1, idx}, ram_wdata=adc_sample, with 1-cycle latency. idx increments on ram_ack.
  - Exit on key 0, or when idx reaches SLOT_DEPTH after the last ack. On exit: length=idx, valid=(idx!=0), mode=MENU.
  - Key 0 with a request pending: the request completes first, and that ack is counted.
- PLAY:
  - Each sample_tick with no pending request issues a read at idx.
  - On ack, dac_sample = sat((ram_rdata * volume) >>> 2) and idx increments.
  - Exit when idx==length or on key 0. dac_sample returns to 0 on exit.
- Overrun: a sample_tick while ram_req=1 in RECORD/PLAY drops the sample and sets overrun. overrun clears only on reset or on entry to RECORD/PLAY.
- Volume keys are honoured in PLAY as well as MENU. E/F in RECORD are ignored.
- Scaling arithmetic: signed product of width SAMPLE_W+3, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. volume=0 outputs 0.
- ram_req never deasserts before ram_ack. At most one request is outstanding.
- Asynchronous reset mid-transfer drops ram_req immediately. Slot contents are treated as lost (valid=0).
- key_valid and sample_tick in the same cycle: the key is processed, and the sample is handled only if the state is unchanged.

Test Plan:
- Reset, then keys B,2, then 10 sample_ticks with 3-cycle ack latency, then key 0 -> 10 writes at addr 0x1000..0x1009 (default params); slot_valid=5'b00010; mode=0.
- Keys A,2 with ram_rdata=0x1000 and volume 4 -> dac_sample=0x1000 for 10 samples; returns to MENU after the 10th ack. Repeat at volume 7 with rdata=0x7000 -> dac_sample=0x7FFF (saturated).
- Record slot 1 with ack withheld across 2 ticks -> exactly one write issued; overrun=1; recorded length counts only acked samples.
- Record all 5 slots -> storage_full=1. Then keys D,D -> slot_valid=0, storage_full=0. Then keys D,1 -> no change, mode=MENU.
- Keys A,3 on an empty slot -> no ram_req; mode=MENU. Key F pressed 6 times from reset -> volume=0, dac_sample=0 during playback.
- Assert reset while ram_req=1 in RECORD -> ram_req=0 asynchronously; all outputs at reset values.
